// File: rtl/alu_issue_ctrl_if.sv
// Handshake, operand and writeback bundle between alu_issue_ctrl and its environment.
// The z_flag signal exists only when ALU_ISSUE_ZFLAG_EN is defined.
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              instr_valid;
    logic              instr_ready;
    logic [7:0]        instr;
    logic              ld_valid;
    logic              ld_ready;
    logic [1:0]        ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [1:0]        alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              wb_done;
    logic [DATA_W-1:0] wb_data;
    logic              c_flag;
`ifdef ALU_ISSUE_ZFLAG_EN
    logic              z_flag;
`endif
    logic              busy;
    logic [1:0]        dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport slave (
`ifdef ALU_ISSUE_ZFLAG_EN
        output z_flag,
`endif
        input  instr_valid, instr, ld_valid, ld_addr, ld_data,
        input  alu_result, alu_carry, dbg_addr,
        output instr_ready, ld_ready, alu_a, alu_b, alu_op,
        output wb_done, wb_data, c_flag, busy, dbg_data
    );

    modport master (
`ifdef ALU_ISSUE_ZFLAG_EN
        input  z_flag,
`endif
        output instr_valid, instr, ld_valid, ld_addr, ld_data,
        output alu_result, alu_carry, dbg_addr,
        input  instr_ready, ld_ready, alu_a, alu_b, alu_op,
        input  wb_done, wb_data, c_flag, busy, dbg_data
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage for ALU_8bit: 4-entry register file, one instruction in flight.
// Latency: accept on edge N, ALU operands held N..N+2, wb_done in cycle N+2; 1 instr / 3 cycles.
// Backpressure: instr_ready only in IDLE with no preload pending; preloads ignored when busy.
// Optional zero flag: define ALU_ISSUE_ZFLAG_EN.
module alu_issue_ctrl #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WB    = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [1:0]        r_alu_op;
    logic [1:0]        r_rd;
    logic              r_wb_done;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_c_flag;

    logic              w_instr_ready;
    logic              w_ld_ready;
    logic              w_accept;
    logic              w_ld_we;
    logic              w_wb_commit;
    logic              w_busy;

    logic [1:0]        w_op;
    logic [1:0]        w_rd;
    logic [1:0]        w_rs1;
    logic [1:0]        w_rs2;

    assign w_op  = bus.instr[7:6];
    assign w_rd  = bus.instr[5:4];
    assign w_rs1 = bus.instr[3:2];
    assign w_rs2 = bus.instr[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Preload wins over an instruction offered in the same IDLE cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_instr_ready = 1'b0;
        w_ld_ready    = 1'b0;
        w_accept      = 1'b0;
        w_ld_we       = 1'b0;
        w_wb_commit   = 1'b0;
        w_busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy        = 1'b0;
                w_ld_ready    = 1'b1;
                w_instr_ready = ~bus.ld_valid;
                w_ld_we       = bus.ld_valid;
                w_accept      = bus.instr_valid & ~bus.ld_valid;
                if (w_accept) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WB;
            end
            S_WB: begin
                w_wb_commit = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_ld_we) begin
            r_regs[bus.ld_addr] <= bus.ld_data;
        end else if (w_wb_commit) begin
            r_regs[r_rd] <= bus.alu_result;
        end
    end

    // Operands are sampled at accept, so ALU inputs stay frozen through ISSUE and WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= '0;
            r_rd      <= '0;
            r_wb_done <= 1'b0;
            r_wb_data <= '0;
            r_c_flag  <= 1'b0;
        end else begin
            r_wb_done <= w_wb_commit;
            if (w_accept) begin
                r_alu_a  <= r_regs[w_rs1];
                r_alu_b  <= r_regs[w_rs2];
                r_alu_op <= w_op;
                r_rd     <= w_rd;
            end
            if (w_wb_commit) begin
                r_wb_data <= bus.alu_result;
                if (!r_alu_op[1]) begin
                    r_c_flag <= bus.alu_carry;
                end
            end
        end
    end

`ifdef ALU_ISSUE_ZFLAG_EN
    logic r_z_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z_flag <= 1'b0;
        end else if (w_wb_commit) begin
            r_z_flag <= (bus.alu_result == '0);
        end
    end

    assign bus.z_flag = r_z_flag;
`endif

    assign bus.instr_ready = w_instr_ready;
    assign bus.ld_ready    = w_ld_ready;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_op      = r_alu_op;
    assign bus.wb_done     = r_wb_done;
    assign bus.wb_data     = r_wb_data;
    assign bus.c_flag      = r_c_flag;
    assign bus.busy        = w_busy;
    assign bus.dbg_data    = r_regs[bus.dbg_addr];
endmodule
